// File: rtl/pipeline_ctrl.sv
// Hazard/stall/flush/forward controller for a 5-stage pipeline with interrupt drain-and-redirect FSM.
// Forwarding and hazard outputs are combinational (zero latency); DMemReady=0 freezes the whole pipe.
module pipeline_ctrl #(
    parameter int DRAIN_CYCLES = 3
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [4:0] Rs1D,
    input  logic [4:0] Rs2D,
    input  logic [4:0] Rs1E,
    input  logic [4:0] Rs2E,
    input  logic [4:0] RdE,
    input  logic [4:0] RdM,
    input  logic [4:0] RdW,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    input  logic       LoadE,
    input  logic       PCSrcE,
    input  logic       IMemReady,
    input  logic       DMemReady,
    input  logic       IrqReq,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       StallM,
    output logic       FlushD,
    output logic       FlushE,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       TrapPCSel,
    output logic       IrqAck
);

    localparam int CW = $clog2(DRAIN_CYCLES) + 1;

    typedef enum logic [1:0] {RUN, DRAIN, REDIRECT} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            load_use;
    logic            irq_go;

    assign ForwardAE = (RegWriteM && RdM != 5'd0 && RdM == Rs1E) ? 2'b10 :
                       (RegWriteW && RdW != 5'd0 && RdW == Rs1E) ? 2'b01 : 2'b00;
    assign ForwardBE = (RegWriteM && RdM != 5'd0 && RdM == Rs2E) ? 2'b10 :
                       (RegWriteW && RdW != 5'd0 && RdW == Rs2E) ? 2'b01 : 2'b00;

    assign load_use = LoadE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
    assign irq_go   = IrqReq && DMemReady && !PCSrcE && !load_use && IMemReady;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Counter only moves while the data side is ready; it never goes below zero.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: begin
                if (irq_go) begin
                    state_d = DRAIN;
                    cnt_d   = CW'(DRAIN_CYCLES - 1);
                end
            end
            DRAIN: begin
                if (DMemReady) begin
                    if (cnt_q == '0) state_d = REDIRECT;
                    else             cnt_d   = cnt_q - 1'b1;
                end
            end
            REDIRECT: begin
                if (DMemReady) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    // FlushD depends only on state_q and pipeline-register-sourced hazard inputs; IrqReq never reaches it.
    always_comb begin
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        TrapPCSel = 1'b0;
        IrqAck    = 1'b0;
        if (RST) begin
            if (!DMemReady) begin
                StallF    = 1'b1;
                StallD    = 1'b1;
                StallE    = 1'b1;
                StallM    = 1'b1;
                TrapPCSel = (state_q == REDIRECT);
                IrqAck    = (state_q == REDIRECT);
            end else begin
                case (state_q)
                    RUN: begin
                        if (PCSrcE) begin
                            FlushD = 1'b1;
                            FlushE = 1'b1;
                        end else if (load_use) begin
                            StallF = 1'b1;
                            StallD = 1'b1;
                            FlushE = 1'b1;
                        end else if (!IMemReady) begin
                            StallF = 1'b1;
                            FlushD = 1'b1;
                        end
                    end
                    DRAIN: begin
                        FlushD = 1'b1;
                        StallF = !PCSrcE;
                        FlushE = PCSrcE || load_use;
                        StallD = !PCSrcE && load_use;
                    end
                    REDIRECT: begin
                        TrapPCSel = 1'b1;
                        IrqAck    = 1'b1;
                        FlushD    = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed plus randomized checks of pipeline_ctrl against a cycle-level behavioural model.
module tb_pipeline_ctrl;

    localparam int DC = 3;

    logic       CLK = 1'b0;
    logic       RST;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic       RegWriteM, RegWriteW, LoadE, PCSrcE, IMemReady, DMemReady, IrqReq;
    logic       StallF, StallD, StallE, StallM, FlushD, FlushE, TrapPCSel, IrqAck;
    logic [1:0] ForwardAE, ForwardBE;
    logic [11:0] obs;

    int n_cmp = 0;
    int n_err = 0;

    // model state: drain cycles still owed, and whether the trap redirect is pending
    int drain_left = 0;
    bit ack_pend   = 0;

    always #5 CLK = ~CLK;

    pipeline_ctrl #(.DRAIN_CYCLES(DC)) dut (
        .CLK(CLK), .RST(RST),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .LoadE(LoadE), .PCSrcE(PCSrcE),
        .IMemReady(IMemReady), .DMemReady(DMemReady), .IrqReq(IrqReq),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .TrapPCSel(TrapPCSel), .IrqAck(IrqAck)
    );

    assign obs = {StallF, StallD, StallE, StallM, FlushD, FlushE, TrapPCSel, IrqAck, ForwardAE, ForwardBE};

    function automatic logic [1:0] m_fwd(input logic [4:0] rs);
        if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
        if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit m_lu();
        return LoadE && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
    endfunction

    function automatic logic [11:0] model_out();
        bit sF, sD, sE, sM, fD, fE, tp, ak;
        {sF, sD, sE, sM, fD, fE, tp, ak} = '0;
        if (RST) begin
            if (!DMemReady) begin
                {sF, sD, sE, sM} = 4'hF;
                tp = ack_pend;
                ak = ack_pend;
            end else if (ack_pend) begin
                {tp, ak, fD} = 3'b111;
            end else if (drain_left > 0) begin
                fD = 1;
                sF = !PCSrcE;
                fE = PCSrcE || m_lu();
                sD = !PCSrcE && m_lu();
            end else if (PCSrcE) begin
                {fD, fE} = 2'b11;
            end else if (m_lu()) begin
                {sF, sD, fE} = 3'b111;
            end else if (!IMemReady) begin
                {sF, fD} = 2'b11;
            end
        end
        return {sF, sD, sE, sM, fD, fE, tp, ak, m_fwd(Rs1E), m_fwd(Rs2E)};
    endfunction

    task automatic model_advance();
        if (!RST) begin
            drain_left = 0;
            ack_pend   = 0;
        end else if (ack_pend) begin
            if (DMemReady) ack_pend = 0;
        end else if (drain_left > 0) begin
            if (DMemReady) begin
                drain_left--;
                if (drain_left == 0) ack_pend = 1;
            end
        end else if (IrqReq && DMemReady && !PCSrcE && !m_lu() && IMemReady) begin
            drain_left = DC;
        end
    endtask

    task automatic check(input string tag, input logic [11:0] o, input logic [11:0] e);
        n_cmp++;
        assert (o === e) else begin
            n_err++;
            $error("FAIL %s: observed %03h expected %03h", tag, o, e);
        end
    endtask

    task automatic at_neg(input string tag);
        @(negedge CLK);
        check(tag, obs, model_out());
    endtask

    task automatic tick();
        @(posedge CLK);
        model_advance();
        #1;
    endtask

    task automatic idle();
        {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
        {RegWriteM, RegWriteW, LoadE, PCSrcE, IrqReq} = '0;
        IMemReady = 1'b1;
        DMemReady = 1'b1;
    endtask

    initial begin
        idle();
        RST = 1'b0;
        LoadE = 1'b1; RdE = 5'd3; Rs1D = 5'd3; IrqReq = 1'b1; IMemReady = 1'b0;
        #2;
        check("reset_zero", obs[11:4], 8'h00);
        at_neg("reset_model");
        tick();
        at_neg("reset_model2");
        tick();
        idle();
        RST = 1'b1;
        at_neg("idle");
        tick();

        RdM = 5'd5; RegWriteM = 1'b1; RdW = 5'd5; RegWriteW = 1'b1; Rs1E = 5'd5;
        at_neg("fwd_mem");
        check("fwdA_10", {10'b0, ForwardAE}, 12'h002);
        RdM = 5'd0;
        #1;
        check("fwdA_01", {10'b0, ForwardAE}, 12'h001);
        check("fwd_wb_model", obs, model_out());
        tick();
        idle();

        LoadE = 1'b1; RdE = 5'd7; Rs2D = 5'd7;
        at_neg("load_use");
        check("load_use_sf_sd_fe", {9'b0, StallF, StallD, FlushE}, 12'h007);
        tick();
        RdE = 5'd0;
        at_neg("load_use_r0");
        check("load_use_r0_none", {9'b0, StallF, StallD, FlushE}, 12'h000);
        tick();
        idle();

        PCSrcE = 1'b1; IMemReady = 1'b0;
        at_neg("branch_imem");
        check("branch_imem_flags", {9'b0, FlushD, FlushE, StallF}, 12'h006);
        tick();
        idle();

        PCSrcE = 1'b1; DMemReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            at_neg("dmem_branch");
            check("dmem_branch_flags", {6'b0, StallF, StallD, StallE, StallM, FlushD, FlushE}, 12'h03C);
            tick();
        end
        idle();

        IrqReq = 1'b1;
        at_neg("irq_entry");
        tick();
        IrqReq = 1'b0;
        for (int i = 0; i < DC; i++) begin
            at_neg("drain");
            check("drain_sf_fd", {10'b0, StallF, FlushD}, 12'h003);
            check("drain_no_ack", {11'b0, IrqAck}, 12'h000);
            tick();
        end
        at_neg("redirect");
        check("redirect_trap_ack", {10'b0, TrapPCSel, IrqAck}, 12'h003);
        tick();
        at_neg("back_to_run");
        check("run_quiet", obs[11:4], 8'h00);
        tick();

        IrqReq = 1'b1;
        at_neg("irq2_entry");
        tick();
        IrqReq = 1'b0;
        at_neg("irq2_drain1");
        tick();
        #2;
        check("irq2_drain2", obs, model_out());
        RST = 1'b0;
        #1;
        check("rst_mid_drain", obs[11:4], 8'h00);
        at_neg("rst_hold");
        tick();
        RST = 1'b1;
        for (int i = 0; i < DC + 3; i++) begin
            at_neg("after_rst");
            check("after_rst_no_ack", {11'b0, IrqAck}, 12'h000);
            tick();
        end

        IrqReq = 1'b1;
        at_neg("irq3_entry");
        tick();
        IrqReq = 1'b0;
        DMemReady = 1'b0;
        at_neg("drain_dmem_a");
        tick();
        at_neg("drain_dmem_b");
        tick();
        DMemReady = 1'b1; PCSrcE = 1'b1;
        at_neg("drain_branch");
        tick();
        PCSrcE = 1'b0; LoadE = 1'b1; RdE = 5'd4; Rs1D = 5'd4;
        at_neg("drain_load_use");
        tick();
        idle();
        at_neg("drain_last");
        tick();
        DMemReady = 1'b0;
        at_neg("redirect_hold_a");
        tick();
        at_neg("redirect_hold_b");
        tick();
        DMemReady = 1'b1;
        at_neg("redirect_go");
        tick();
        at_neg("run_after");
        tick();

        for (int i = 0; i < 800; i++) begin
            Rs1D = 5'($urandom_range(0, 7));
            Rs2D = 5'($urandom_range(0, 7));
            Rs1E = 5'($urandom_range(0, 7));
            Rs2E = 5'($urandom_range(0, 7));
            RdE  = 5'($urandom_range(0, 7));
            RdM  = 5'($urandom_range(0, 7));
            RdW  = 5'($urandom_range(0, 7));
            RegWriteM = 1'($urandom_range(0, 1));
            RegWriteW = 1'($urandom_range(0, 1));
            LoadE     = ($urandom_range(0, 2) == 0);
            PCSrcE    = ($urandom_range(0, 7) == 0);
            IMemReady = ($urandom_range(0, 5) != 0);
            DMemReady = ($urandom_range(0, 5) != 0);
            IrqReq    = ($urandom_range(0, 4) == 0);
            RST       = ($urandom_range(0, 79) != 0);
            at_neg("random");
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
